// File: rtl/uart_rxtx_param_if.sv
// Handshake and serial-pin bundle for uart_rxtx_param.
// The slave modport is the transceiver side; master is the system/pin side.
interface uart_rxtx_param_if #(
   parameter int unsigned DATA_W = 8
);
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic              parity_en;
   logic              parity_type;
   logic              tx;
   logic              tx_busy;
   logic              tx_done;
   logic              rx;
   logic [DATA_W-1:0] rx_msg;
   logic              rx_parity;
   logic              rx_complete;
   logic              rx_parity_err;
   logic              rx_frame_err;

   modport master (
      output tx_start, tx_data, parity_en, parity_type, rx,
      input  tx, tx_busy, tx_done, rx_msg, rx_parity, rx_complete, rx_parity_err, rx_frame_err
   );

   modport slave (
      input  tx_start, tx_data, parity_en, parity_type, rx,
      output tx, tx_busy, tx_done, rx_msg, rx_parity, rx_complete, rx_parity_err, rx_frame_err
   );
endinterface

// File: rtl/uart_rxtx_param.sv
// Parametrised full-duplex UART (independent TX and RX FSMs).
// Optional macro UART_LOOPBACK_EN adds a loopback input that routes internal tx into RX.
module uart_rxtx_param #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 14,
   parameter bit          MSB_FIRST    = 1'b1,
   parameter int unsigned STOP_BITS    = 1,
   parameter logic [15:0] ERR_CODE     = 16'h3F
) (
   input logic              clk_3125,
   input logic              reset,
`ifdef UART_LOOPBACK_EN
   input logic              loopback,
`endif
   uart_rxtx_param_if.slave bus
);
   localparam int unsigned StopCycles = STOP_BITS * CLKS_PER_BIT;
   localparam int unsigned CntW       = $clog2(StopCycles);
   localparam int unsigned IdxW       = $clog2(DATA_W);

   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] StopLast = CntW'(StopCycles - 1);
   localparam logic [CntW-1:0] HalfCnt  = CntW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [IdxW-1:0] IdxFirst = MSB_FIRST ? IdxW'(DATA_W - 1) : '0;
   localparam logic [IdxW-1:0] IdxLast  = MSB_FIRST ? '0 : IdxW'(DATA_W - 1);
   localparam logic [IdxW-1:0] StopIdx  = IdxW'(STOP_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   // TX state
   state_e            tx_state_q, tx_state_d;
   logic [CntW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [IdxW-1:0]   tx_idx_q, tx_idx_d;
   logic [IdxW-1:0]   tx_idx_nxt;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              tx_par_q, tx_par_d;
   logic              tx_pen_q, tx_pen_d;
   logic              tx_q, tx_d;
   logic              tx_last_stop, tx_accept;

   // RX state
   logic              rx_src, rx_s1_q, rx_s2_q;
   state_e            rx_state_q, rx_state_d;
   logic [CntW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [IdxW-1:0]   rx_idx_q, rx_idx_d;
   logic [IdxW-1:0]   rx_idx_nxt;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic              rx_rpar_q, rx_rpar_d;
   logic              rx_pen_q, rx_pen_d;
   logic              rx_ptype_q, rx_ptype_d;
   logic              rx_ferr_acc_q, rx_ferr_acc_d;
   logic [DATA_W-1:0] rx_msg_q, rx_msg_d;
   logic              rx_parity_q, rx_parity_d;
   logic              rx_complete_q, rx_complete_d;
   logic              rx_perr_q, rx_perr_d;
   logic              rx_ferr_q, rx_ferr_d;
   logic              rx_perr_now, rx_ferr_now;

`ifdef UART_LOOPBACK_EN
   assign rx_src = loopback ? tx_q : bus.rx;
   assign bus.tx = loopback ? 1'b1 : tx_q;
`else
   assign rx_src = bus.rx;
   assign bus.tx = tx_q;
`endif

   assign tx_last_stop = (tx_state_q == StStop) && (tx_cnt_q == StopLast);
   // Accepting in the final stop cycle gives zero-gap back-to-back frames.
   assign tx_accept    = bus.tx_start && ((tx_state_q == StIdle) || tx_last_stop);
   assign tx_idx_nxt   = MSB_FIRST ? tx_idx_q - 1'b1 : tx_idx_q + 1'b1;
   assign bus.tx_busy  = (tx_state_q != StIdle);
   assign bus.tx_done  = tx_last_stop;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_data_d  = tx_data_q;
      tx_par_d   = tx_par_q;
      tx_pen_d   = tx_pen_q;
      tx_d       = tx_q;
      unique case (tx_state_q)
         StIdle: tx_d = 1'b1;
         StStart: begin
            if (tx_cnt_q == BitLast) begin
               tx_state_d = StData;
               tx_cnt_d   = '0;
               tx_idx_d   = IdxFirst;
               tx_d       = tx_data_q[IdxFirst];
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         StData: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d = '0;
               if (tx_idx_q == IdxLast) begin
                  tx_state_d = tx_pen_q ? StParity : StStop;
                  tx_d       = tx_pen_q ? tx_par_q : 1'b1;
               end else begin
                  tx_idx_d = tx_idx_nxt;
                  tx_d     = tx_data_q[tx_idx_nxt];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         StParity: begin
            if (tx_cnt_q == BitLast) begin
               tx_state_d = StStop;
               tx_cnt_d   = '0;
               tx_d       = 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (tx_last_stop) begin
               tx_state_d = StIdle;
               tx_cnt_d   = '0;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = StIdle;
      endcase
      if (tx_accept) begin
         tx_state_d = StStart;
         tx_cnt_d   = '0;
         tx_data_d  = bus.tx_data;
         tx_par_d   = (^bus.tx_data) ^ bus.parity_type;
         tx_pen_d   = bus.parity_en;
         tx_d       = 1'b0;
      end
   end

   assign rx_idx_nxt  = MSB_FIRST ? rx_idx_q - 1'b1 : rx_idx_q + 1'b1;
   assign rx_perr_now = rx_pen_q & (rx_rpar_q != ((^rx_shift_q) ^ rx_ptype_q));
   assign rx_ferr_now = rx_ferr_acc_q | ~rx_s2_q;

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q;
      rx_idx_d      = rx_idx_q;
      rx_shift_d    = rx_shift_q;
      rx_rpar_d     = rx_rpar_q;
      rx_pen_d      = rx_pen_q;
      rx_ptype_d    = rx_ptype_q;
      rx_ferr_acc_d = rx_ferr_acc_q;
      rx_msg_d      = rx_msg_q;
      rx_parity_d   = rx_parity_q;
      rx_perr_d     = rx_perr_q;
      rx_ferr_d     = rx_ferr_q;
      rx_complete_d = 1'b0;
      unique case (rx_state_q)
         StIdle: begin
            if (!rx_s2_q) begin
               rx_state_d = StStart;
               rx_cnt_d   = '0;
            end
         end
         StStart: begin
            if (rx_cnt_q == HalfCnt) begin
               rx_cnt_d = '0;
               if (rx_s2_q) begin
                  rx_state_d = StIdle;
               end else begin
                  rx_state_d    = StData;
                  rx_idx_d      = IdxFirst;
                  rx_pen_d      = bus.parity_en;
                  rx_ptype_d    = bus.parity_type;
                  rx_ferr_acc_d = 1'b0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         StData: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d             = '0;
               rx_shift_d[rx_idx_q] = rx_s2_q;
               if (rx_idx_q == IdxLast) begin
                  rx_state_d = rx_pen_q ? StParity : StStop;
                  rx_idx_d   = '0;
               end else begin
                  rx_idx_d = rx_idx_nxt;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         StParity: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = '0;
               rx_rpar_d  = rx_s2_q;
               rx_state_d = StStop;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d = '0;
               if (rx_idx_q == StopIdx) begin
                  // Deliver now; back in IDLE half a bit early to catch the next edge.
                  rx_state_d    = StIdle;
                  rx_complete_d = 1'b1;
                  rx_perr_d     = rx_perr_now;
                  rx_ferr_d     = rx_ferr_now;
                  rx_msg_d      = rx_perr_now ? DATA_W'(ERR_CODE) : rx_shift_q;
                  rx_parity_d   = (rx_pen_q && !rx_perr_now) ? rx_rpar_q : 1'b0;
               end else begin
                  rx_idx_d      = rx_idx_q + 1'b1;
                  rx_ferr_acc_d = rx_ferr_now;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = StIdle;
      endcase
   end

   assign bus.rx_msg        = rx_msg_q;
   assign bus.rx_parity     = rx_parity_q;
   assign bus.rx_complete   = rx_complete_q;
   assign bus.rx_parity_err = rx_perr_q;
   assign bus.rx_frame_err  = rx_ferr_q;

   always_ff @(posedge clk_3125) begin
      if (reset) begin
         tx_state_q    <= StIdle;
         tx_cnt_q      <= '0;
         tx_idx_q      <= '0;
         tx_data_q     <= '0;
         tx_par_q      <= 1'b0;
         tx_pen_q      <= 1'b0;
         tx_q          <= 1'b1;
         rx_s1_q       <= 1'b1;
         rx_s2_q       <= 1'b1;
         rx_state_q    <= StIdle;
         rx_cnt_q      <= '0;
         rx_idx_q      <= '0;
         rx_shift_q    <= '0;
         rx_rpar_q     <= 1'b0;
         rx_pen_q      <= 1'b0;
         rx_ptype_q    <= 1'b0;
         rx_ferr_acc_q <= 1'b0;
         rx_msg_q      <= '0;
         rx_parity_q   <= 1'b0;
         rx_complete_q <= 1'b0;
         rx_perr_q     <= 1'b0;
         rx_ferr_q     <= 1'b0;
      end else begin
         tx_state_q    <= tx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_idx_q      <= tx_idx_d;
         tx_data_q     <= tx_data_d;
         tx_par_q      <= tx_par_d;
         tx_pen_q      <= tx_pen_d;
         tx_q          <= tx_d;
         rx_s1_q       <= rx_src;
         rx_s2_q       <= rx_s1_q;
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_idx_q      <= rx_idx_d;
         rx_shift_q    <= rx_shift_d;
         rx_rpar_q     <= rx_rpar_d;
         rx_pen_q      <= rx_pen_d;
         rx_ptype_q    <= rx_ptype_d;
         rx_ferr_acc_q <= rx_ferr_acc_d;
         rx_msg_q      <= rx_msg_d;
         rx_parity_q   <= rx_parity_d;
         rx_complete_q <= rx_complete_d;
         rx_perr_q     <= rx_perr_d;
         rx_ferr_q     <= rx_ferr_d;
      end
   end
endmodule

// File: tb/tb_uart_rxtx_param.sv
// Randomised self-checking bench for uart_rxtx_param: an 8-bit MSB-first instance and a
// 7-bit LSB-first two-stop-bit instance looped back on itself.
module tb_uart_rxtx_param;
   localparam int unsigned C = 14;
   localparam logic [7:0] Err8 = 8'h3F;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   logic [7:0] last_msg = 8'h00;

   always #5 clk = ~clk;

   uart_rxtx_param_if #(.DATA_W(8)) bus8 ();
   uart_rxtx_param_if #(.DATA_W(7)) bus7 ();

`ifdef UART_LOOPBACK_EN
   assign bus7.rx = 1'b0;
`else
   assign bus7.rx = bus7.tx;
`endif

   uart_rxtx_param #(
      .DATA_W(8), .CLKS_PER_BIT(C), .MSB_FIRST(1'b1), .STOP_BITS(1), .ERR_CODE(16'h3F)
   ) u_dut8 (
      .clk_3125 (clk),
      .reset    (reset),
`ifdef UART_LOOPBACK_EN
      .loopback (1'b0),
`endif
      .bus      (bus8)
   );

   uart_rxtx_param #(
      .DATA_W(7), .CLKS_PER_BIT(C), .MSB_FIRST(1'b0), .STOP_BITS(2), .ERR_CODE(16'h3F)
   ) u_dut7 (
      .clk_3125 (clk),
      .reset    (reset),
`ifdef UART_LOOPBACK_EN
      .loopback (1'b1),
`endif
      .bus      (bus7)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected serial waveform, one entry per clock, built from the frame definition.
   function automatic void build_tx(input logic [15:0] d, input int unsigned dw, input bit msb,
                                    input bit pen, input bit ptype, input int unsigned stops,
                                    output logic [511:0] w, output int len);
      bit fb[$];
      fb.push_back(1'b0);
      for (int k = 0; k < int'(dw); k++) fb.push_back(msb ? d[dw-1-k] : d[k]);
      if (pen) fb.push_back((^d) ^ ptype);
      for (int k = 0; k < int'(stops); k++) fb.push_back(1'b1);
      w   = '1;
      len = 0;
      foreach (fb[j]) begin
         for (int c = 0; c < int'(C); c++) begin
            w[len] = fb[j];
            len++;
         end
      end
   endfunction

   task automatic test_reset();
      reset            = 1'b1;
      bus8.tx_start    = 1'b0;
      bus8.tx_data     = '0;
      bus8.parity_en   = 1'b0;
      bus8.parity_type = 1'b0;
      bus8.rx          = 1'b1;
      bus7.tx_start    = 1'b0;
      bus7.tx_data     = '0;
      bus7.parity_en   = 1'b0;
      bus7.parity_type = 1'b0;
      repeat (3) tick();
      n_total++;
      if (bus8.tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus8.tx);
      else n_pass++;
      n_total++;
      if ({bus8.tx_busy, bus8.tx_done} !== 2'b00)
         $display("FAIL reset_tx_flags: got %b want 00", {bus8.tx_busy, bus8.tx_done});
      else n_pass++;
      n_total++;
      if ({bus8.rx_msg, bus8.rx_parity, bus8.rx_complete, bus8.rx_parity_err,
           bus8.rx_frame_err} !== 12'h000)
         $display("FAIL reset_rx: got %h want 000", {bus8.rx_msg, bus8.rx_parity,
                  bus8.rx_complete, bus8.rx_parity_err, bus8.rx_frame_err});
      else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_tx_frame(input logic [7:0] d, input bit pen, input bit ptype);
      logic [511:0] exp_w, obs_w, exp_b, obs_b, exp_d, obs_d;
      int len;
      build_tx(16'(d), 8, 1'b1, pen, ptype, 1, exp_w, len);
      obs_w = '1; obs_b = '0; obs_d = '0; exp_b = '0; exp_d = '0;
      for (int i = 0; i < len; i++) exp_b[i] = 1'b1;
      exp_d[len-1] = 1'b1;
      bus8.tx_data     = d;
      bus8.parity_en   = pen;
      bus8.parity_type = ptype;
      bus8.tx_start    = 1'b1;
      tick();
      bus8.tx_start    = 1'b0;
      bus8.tx_data     = 8'($urandom);
      bus8.parity_en   = 1'($urandom);
      bus8.parity_type = 1'($urandom);
      for (int i = 0; i < len; i++) begin
         obs_w[i] = bus8.tx;
         obs_b[i] = bus8.tx_busy;
         obs_d[i] = bus8.tx_done;
         tick();
      end
      n_total++;
      if (obs_w !== exp_w) $display("FAIL tx_wave d=%h: got %h want %h", d, obs_w, exp_w);
      else n_pass++;
      n_total++;
      if (obs_b !== exp_b) $display("FAIL tx_busy d=%h: got %h want %h", d, obs_b, exp_b);
      else n_pass++;
      n_total++;
      if (obs_d !== exp_d) $display("FAIL tx_done d=%h: got %h want %h", d, obs_d, exp_d);
      else n_pass++;
      n_total++;
      if ({bus8.tx, bus8.tx_busy} !== 2'b10)
         $display("FAIL tx_idle_after d=%h: got %b want 10", d, {bus8.tx, bus8.tx_busy});
      else n_pass++;
   endtask

   task automatic test_rx_frame(input logic [7:0] d, input bit pen, input bit ptype,
                                input bit flip, input bit stop_bad);
      bit fb[$];
      bit par_sent, exp_perr, exp_par;
      logic [7:0] exp_msg, cap_msg;
      logic [2:0] cap_flags;
      int pulses;
      par_sent = (^d) ^ ptype ^ flip;
      exp_perr = pen && (par_sent != ((^d) ^ ptype));
      exp_msg  = exp_perr ? Err8 : d;
      exp_par  = (pen && !exp_perr) ? par_sent : 1'b0;
      fb.push_back(1'b0);
      for (int k = 7; k >= 0; k--) fb.push_back(d[k]);
      if (pen) fb.push_back(par_sent);
      fb.push_back(!stop_bad);
      bus8.parity_en   = pen;
      bus8.parity_type = ptype;
      pulses    = 0;
      cap_msg   = '0;
      cap_flags = '0;
      foreach (fb[j]) begin
         if (j == 3) begin
            bus8.parity_en   = 1'($urandom);
            bus8.parity_type = 1'($urandom);
         end
         for (int c = 0; c < int'(C); c++) begin
            bus8.rx = fb[j];
            tick();
            if (bus8.rx_complete === 1'b1) begin
               pulses++;
               cap_msg   = bus8.rx_msg;
               cap_flags = {bus8.rx_parity, bus8.rx_parity_err, bus8.rx_frame_err};
            end
         end
      end
      bus8.rx = 1'b1;
      for (int c = 0; c < int'(2 * C); c++) begin
         tick();
         if (bus8.rx_complete === 1'b1) begin
            pulses++;
            cap_msg   = bus8.rx_msg;
            cap_flags = {bus8.rx_parity, bus8.rx_parity_err, bus8.rx_frame_err};
         end
      end
      n_total++;
      if (pulses != 1) $display("FAIL rx_pulses d=%h: got %0d want 1", d, pulses);
      else n_pass++;
      n_total++;
      if (cap_msg !== exp_msg) $display("FAIL rx_msg d=%h: got %h want %h", d, cap_msg, exp_msg);
      else n_pass++;
      n_total++;
      if (cap_flags !== {exp_par, exp_perr, stop_bad})
         $display("FAIL rx_flags d=%h: got %b want %b", d, cap_flags,
                  {exp_par, exp_perr, stop_bad});
      else n_pass++;
      n_total++;
      if (bus8.rx_msg !== exp_msg)
         $display("FAIL rx_msg_hold d=%h: got %h want %h", d, bus8.rx_msg, exp_msg);
      else n_pass++;
      last_msg = exp_msg;
   endtask

   task automatic test_false_start();
      int pulses = 0;
      bus8.rx = 1'b0;
      repeat (4) tick();
      bus8.rx = 1'b1;
      for (int c = 0; c < int'(3 * C); c++) begin
         tick();
         if (bus8.rx_complete === 1'b1) pulses++;
      end
      n_total++;
      if (pulses != 0) $display("FAIL false_start_pulses: got %0d want 0", pulses);
      else n_pass++;
      n_total++;
      if (bus8.rx_msg !== last_msg)
         $display("FAIL false_start_hold: got %h want %h", bus8.rx_msg, last_msg);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [511:0] w1, w2, exp_w, obs_w, obs_b, exp_b, obs_d, exp_d;
      int len1, len2, tot;
      build_tx(16'h01, 8, 1'b1, 1'b1, 1'b0, 1, w1, len1);
      build_tx(16'h80, 8, 1'b1, 1'b1, 1'b0, 1, w2, len2);
      tot   = len1 + len2;
      exp_w = w1;
      for (int j = 0; j < len2; j++) exp_w[len1+j] = w2[j];
      exp_b = '0; exp_d = '0; obs_w = '1; obs_b = '0; obs_d = '0;
      for (int i = 0; i < tot; i++) exp_b[i] = 1'b1;
      exp_d[len1-1] = 1'b1;
      exp_d[tot-1]  = 1'b1;
      bus8.parity_en   = 1'b1;
      bus8.parity_type = 1'b0;
      bus8.tx_data     = 8'h01;
      bus8.tx_start    = 1'b1;
      tick();
      for (int i = 0; i < tot; i++) begin
         obs_w[i] = bus8.tx;
         obs_b[i] = bus8.tx_busy;
         obs_d[i] = bus8.tx_done;
         if (i == 0) bus8.tx_data = 8'h80;
         if (i == len1 + 5) bus8.tx_start = 1'b0;
         tick();
      end
      n_total++;
      if (obs_w !== exp_w) $display("FAIL b2b_wave: got %h want %h", obs_w, exp_w);
      else n_pass++;
      n_total++;
      if (obs_b !== exp_b) $display("FAIL b2b_busy: got %h want %h", obs_b, exp_b);
      else n_pass++;
      n_total++;
      if (obs_d !== exp_d) $display("FAIL b2b_done: got %h want %h", obs_d, exp_d);
      else n_pass++;
      n_total++;
      if ({bus8.tx, bus8.tx_busy} !== 2'b10)
         $display("FAIL b2b_idle_after: got %b want 10", {bus8.tx, bus8.tx_busy});
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int dones = 0, lows = 0, cpls = 0;
      bus8.parity_en   = 1'b1;
      bus8.parity_type = 1'b0;
      bus8.tx_data     = 8'hA5;
      bus8.tx_start    = 1'b1;
      bus8.rx          = 1'b0;
      tick();
      bus8.tx_start = 1'b0;
      repeat (3 * C) tick();
      reset   = 1'b1;
      bus8.rx = 1'b1;
      tick();
      n_total++;
      if ({bus8.tx, bus8.tx_busy, bus8.tx_done} !== 3'b100)
         $display("FAIL rst_mid_tx: got %b want 100", {bus8.tx, bus8.tx_busy, bus8.tx_done});
      else n_pass++;
      n_total++;
      if (bus8.rx_msg !== 8'h00) $display("FAIL rst_mid_rx_msg: got %h want 00", bus8.rx_msg);
      else n_pass++;
      reset = 1'b0;
      for (int c = 0; c < int'(12 * C); c++) begin
         tick();
         if (bus8.tx_done === 1'b1) dones++;
         if (bus8.tx !== 1'b1) lows++;
         if (bus8.rx_complete === 1'b1) cpls++;
      end
      n_total++;
      if (dones != 0) $display("FAIL rst_mid_done: got %0d want 0", dones);
      else n_pass++;
      n_total++;
      if (lows != 0) $display("FAIL rst_mid_tx_low: got %0d want 0", lows);
      else n_pass++;
      n_total++;
      if (cpls != 0) $display("FAIL rst_mid_rx_complete: got %0d want 0", cpls);
      else n_pass++;
   endtask

   task automatic test_loopback(input logic [6:0] d);
      logic [511:0] exp_w, obs_w;
      logic [6:0] cap_msg;
      logic [2:0] cap_flags;
      int len, pulses;
      build_tx(16'(d), 7, 1'b0, 1'b0, 1'b0, 2, exp_w, len);
`ifdef UART_LOOPBACK_EN
      exp_w = '1;
`endif
      obs_w = '1; pulses = 0; cap_msg = '0; cap_flags = 3'b111;
      bus7.tx_data     = d;
      bus7.parity_en   = 1'b0;
      bus7.parity_type = 1'($urandom);
      bus7.tx_start    = 1'b1;
      tick();
      bus7.tx_start = 1'b0;
      for (int i = 0; i < len + int'(3 * C); i++) begin
         if (i < len) obs_w[i] = bus7.tx;
         if (bus7.rx_complete === 1'b1) begin
            pulses++;
            cap_msg   = bus7.rx_msg;
            cap_flags = {bus7.rx_parity, bus7.rx_parity_err, bus7.rx_frame_err};
         end
         tick();
      end
      n_total++;
      if (obs_w !== exp_w) $display("FAIL lb_tx_pin d=%h: got %h want %h", d, obs_w, exp_w);
      else n_pass++;
      n_total++;
      if (pulses != 1) $display("FAIL lb_pulses d=%h: got %0d want 1", d, pulses);
      else n_pass++;
      n_total++;
      if (cap_msg !== d) $display("FAIL lb_msg: got %h want %h", cap_msg, d);
      else n_pass++;
      n_total++;
      if (cap_flags !== 3'b000) $display("FAIL lb_flags d=%h: got %b want 000", d, cap_flags);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_tx_frame(8'hA5, 1'b1, 1'b0);
      for (int n = 0; n < 5; n++) test_tx_frame(8'($urandom), 1'($urandom), 1'($urandom));
      test_rx_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      test_rx_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 6; n++)
         test_rx_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(3, 0) == 0));
      test_false_start();
      test_rx_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      test_rx_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
      test_back_to_back();
      test_reset_mid_frame();
      test_loopback(7'h55);
      for (int n = 0; n < 2; n++) test_loopback(7'($urandom));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
